// File: rtl/movement_pkg.sv
// Shared definitions for the movement timing path: FSM state encodings and
// active-low seven-segment patterns ({g,f,e,d,c,b,a}) used by the display mux.
package movement_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Digit codes that do not map to a decimal digit
  localparam logic [3:0] CODE_E    = 4'hE;
  localparam logic [3:0] CODE_DASH = 4'hF;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, 0 = segment lit
  localparam logic [6:0] SEG7_0    = 7'b100_0000;
  localparam logic [6:0] SEG7_1    = 7'b111_1001;
  localparam logic [6:0] SEG7_2    = 7'b010_0100;
  localparam logic [6:0] SEG7_3    = 7'b011_0000;
  localparam logic [6:0] SEG7_4    = 7'b001_1001;
  localparam logic [6:0] SEG7_5    = 7'b001_0010;
  localparam logic [6:0] SEG7_6    = 7'b000_0010;
  localparam logic [6:0] SEG7_7    = 7'b111_1000;
  localparam logic [6:0] SEG7_8    = 7'b000_0000;
  localparam logic [6:0] SEG7_9    = 7'b001_0000;
  localparam logic [6:0] SEG7_E    = 7'b000_0110;
  localparam logic [6:0] SEG7_DASH = 7'b011_1111;

endpackage

// File: rtl/seg7_digit_decoder.sv
// Combinational 4-bit code to active-low seven-segment pattern.
// Codes 0..9 give decimal digits, CODE_E gives 'E', anything else gives '-'.
module seg7_digit_decoder
  import movement_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg7
);

  // Look up the segment pattern for the requested code
  always_comb begin
    seg7 = SEG7_DASH;
    case (code)
      4'd0:    seg7 = SEG7_0;
      4'd1:    seg7 = SEG7_1;
      4'd2:    seg7 = SEG7_2;
      4'd3:    seg7 = SEG7_3;
      4'd4:    seg7 = SEG7_4;
      4'd5:    seg7 = SEG7_5;
      4'd6:    seg7 = SEG7_6;
      4'd7:    seg7 = SEG7_7;
      4'd8:    seg7 = SEG7_8;
      4'd9:    seg7 = SEG7_9;
      CODE_E:  seg7 = SEG7_E;
      default: seg7 = SEG7_DASH;
    endcase
  end

endmodule

// File: rtl/movement_step_timer.sv
// Step timing source for the movement path: synchronises the speed switches
// and LD enable, runs the IDLE/RUN/ERR FSM, emits one tempo pulse per period
// (BASE_PERIOD << mode), counts steps and drives the mode digit display.
module movement_step_timer
  import movement_pkg::*;
#(
  parameter  int N_MODES     = 3,
  parameter  int BASE_PERIOD = 130_000_000,
  parameter  int STEP_W      = 8,
  localparam int MODE_W      = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_MODES-1:0] sel,
  input  logic              ld,
  output logic              tempo,
  output logic [STEP_W-1:0] step_count,
  output logic [MODE_W-1:0] mode_idx,
  output logic              running,
  output logic              error,
  output logic [7:0]        seg
);

  // Counter must hold the longest period minus one
  localparam longint unsigned MAX_PERIOD = 64'(BASE_PERIOD) << (N_MODES - 1);
  localparam int CNT_W = $clog2(MAX_PERIOD);

  logic [N_MODES-1:0] sel_meta_q, sel_meta_d, sel_s_q, sel_s_d;
  logic               ld_meta_q, ld_meta_d, ld_s_q, ld_s_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, term_cnt;
  logic [MODE_W-1:0]  mode_idx_q, mode_idx_d, sel_mode;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               tempo_q, tempo_d;
  logic               running_q, running_d;
  logic               error_q, error_d;
  logic [7:0]         seg_q, seg_d;
  logic [3:0]         digit_code;
  logic [6:0]         digit_seg7;
  logic               sel_invalid, sel_any;

  // Terminal count of the active mode, chosen from elaboration-time constants
  always_comb begin
    term_cnt = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if (mode_idx_q == MODE_W'(k)) term_cnt = CNT_W'((64'(BASE_PERIOD) << k) - 64'd1);
    end
  end

  // Classify the synchronised switches and encode the selected mode
  always_comb begin
    sel_invalid = ($countones(sel_s_q) > 1);
    sel_any     = (sel_s_q != '0);
    sel_mode    = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if (sel_s_q[k]) sel_mode = MODE_W'(k);
    end
  end

  // Next state, period counter, step counter and output decode
  always_comb begin
    sel_meta_d = sel;
    sel_s_d    = sel_meta_q;
    ld_meta_d  = ld;
    ld_s_d     = ld_meta_q;
    state_d    = state_q;
    mode_idx_d = mode_idx_q;
    cnt_d      = '0;
    tempo_d    = 1'b0;
    step_d     = step_q;

    if (sel_invalid) begin
      state_d = ST_ERR;
    end else if (!sel_any || !ld_s_q) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_RUN) begin
      state_d    = ST_RUN;
      mode_idx_d = sel_mode;
    end else if (sel_mode != mode_idx_q) begin
      mode_idx_d = sel_mode;
    end else if (cnt_q == term_cnt) begin
      tempo_d = 1'b1;
      step_d  = step_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    running_d = (state_d == ST_RUN);
    error_d   = (state_d == ST_ERR);

    case (state_d)
      ST_RUN:  digit_code = 4'(mode_idx_d) + 4'd1;
      ST_ERR:  digit_code = CODE_E;
      default: digit_code = CODE_DASH;
    endcase
    seg_d = {~running_d, digit_seg7};
  end

  seg7_digit_decoder u_digit (
    .code (digit_code),
    .seg7 (digit_seg7)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_meta_q <= '0;
      sel_s_q    <= '0;
      ld_meta_q  <= 1'b0;
      ld_s_q     <= 1'b0;
      state_q    <= ST_IDLE;
      mode_idx_q <= '0;
      cnt_q      <= '0;
      tempo_q    <= 1'b0;
      step_q     <= '0;
      running_q  <= 1'b0;
      error_q    <= 1'b0;
      seg_q      <= {1'b1, SEG7_DASH};
    end else begin
      sel_meta_q <= sel_meta_d;
      sel_s_q    <= sel_s_d;
      ld_meta_q  <= ld_meta_d;
      ld_s_q     <= ld_s_d;
      state_q    <= state_d;
      mode_idx_q <= mode_idx_d;
      cnt_q      <= cnt_d;
      tempo_q    <= tempo_d;
      step_q     <= step_d;
      running_q  <= running_d;
      error_q    <= error_d;
      seg_q      <= seg_d;
    end
  end

  assign tempo      = tempo_q;
  assign step_count = step_q;
  assign mode_idx   = mode_idx_q;
  assign running    = running_q;
  assign error      = error_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_movement_step_timer.sv
// Directed bench for movement_step_timer with a short base period (4 cycles),
// three modes and a 4-bit step counter so wrap-around is reachable quickly.
module tb_movement_step_timer;

  localparam int N_MODES     = 3;
  localparam int BASE_PERIOD = 4;
  localparam int STEP_W      = 4;

  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_E    = 8'h86;
  localparam logic [7:0] SEG_1    = 8'h79;
  localparam logic [7:0] SEG_2    = 8'h24;
  localparam logic [7:0] SEG_3    = 8'h30;

  logic              clk;
  logic              rst;
  logic [2:0]        sel;
  logic              ld;
  logic              tempo;
  logic [STEP_W-1:0] step_count;
  logic [1:0]        mode_idx;
  logic              running;
  logic              error;
  logic [7:0]        seg;

  int vecCount  = 0;
  int missCount = 0;

  movement_step_timer #(
    .N_MODES     (N_MODES),
    .BASE_PERIOD (BASE_PERIOD),
    .STEP_W      (STEP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .ld         (ld),
    .tempo      (tempo),
    .step_count (step_count),
    .mode_idx   (mode_idx),
    .running    (running),
    .error      (error),
    .seg        (seg)
  );

  // Free-running 100 MHz-style clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n cycles; inputs are driven and outputs sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] s, input logic l);
    rst = r;
    sel = s;
    ld  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_running"}, 32'(running), 32'd0);
    checkOutput({tag, "_error"},   32'(error),   32'd0);
    checkOutput({tag, "_tempo"},   32'(tempo),   32'd0);
    checkOutput({tag, "_step"},    32'(step_count), 32'd0);
    checkOutput({tag, "_mode"},    32'(mode_idx), 32'd0);
    checkOutput({tag, "_seg"},     32'(seg),     32'(SEG_DASH));
  endtask

  // Count cycles until the next tempo pulse (bounded), then check spacing and step count
  task automatic waitTempo(input string tag, input int expSpacing, input logic [STEP_W-1:0] expStep);
    int n;
    n = -1;
    for (int c = 1; c <= 64; c++) begin
      tick(1);
      if (tempo === 1'b1) begin
        n = c;
        break;
      end
    end
    checkOutput({tag, "_spacing"}, 32'(n), 32'(expSpacing));
    checkOutput({tag, "_step"}, 32'(step_count), 32'(expStep));
  endtask

  initial begin
    // 1: reset, then mode 0 run
    applyStimulus(1'b1, 3'b001, 1'b1);
    tick(2);
    checkResetState("rst");
    applyStimulus(1'b0, 3'b001, 1'b1);
    tick(2);
    checkOutput("t1_not_yet_running", 32'(running), 32'd0);
    tick(1);
    checkOutput("t1_running", 32'(running), 32'd1);
    checkOutput("t1_seg", 32'(seg), 32'(SEG_1));
    checkOutput("t1_mode", 32'(mode_idx), 32'd0);
    waitTempo("t1_p1", 4, 4'd1);
    waitTempo("t1_p2", 4, 4'd2);

    // 2: switch to mode 2 while running
    applyStimulus(1'b0, 3'b100, 1'b1);
    tick(2);
    checkOutput("t2_mode_before", 32'(mode_idx), 32'd0);
    checkOutput("t2_no_tempo", 32'(tempo), 32'd0);
    tick(1);
    checkOutput("t2_mode", 32'(mode_idx), 32'd2);
    checkOutput("t2_seg", 32'(seg), 32'(SEG_3));
    checkOutput("t2_running", 32'(running), 32'd1);
    waitTempo("t2_p1", 16, 4'd3);
    waitTempo("t2_p2", 16, 4'd4);

    // 3: invalid selection, then mode 1
    applyStimulus(1'b0, 3'b011, 1'b1);
    tick(3);
    checkOutput("t3_error", 32'(error), 32'd1);
    checkOutput("t3_running", 32'(running), 32'd0);
    checkOutput("t3_seg", 32'(seg), 32'(SEG_E));
    tick(8);
    checkOutput("t3_no_tempo", 32'(tempo), 32'd0);
    checkOutput("t3_step_hold", 32'(step_count), 32'd4);
    applyStimulus(1'b0, 3'b010, 1'b1);
    tick(3);
    checkOutput("t3_rerun", 32'(running), 32'd1);
    checkOutput("t3_error_clr", 32'(error), 32'd0);
    checkOutput("t3_mode", 32'(mode_idx), 32'd1);
    checkOutput("t3_seg2", 32'(seg), 32'(SEG_2));
    waitTempo("t3_p1", 8, 4'd5);

    // 4: ld falls so its synchronised value arrives on the terminal-count cycle
    tick(5);
    applyStimulus(1'b0, 3'b010, 1'b0);
    tick(2);
    checkOutput("t4_still_running", 32'(running), 32'd1);
    tick(1);
    checkOutput("t4_exit_running", 32'(running), 32'd0);
    checkOutput("t4_exit_tempo", 32'(tempo), 32'd0);
    checkOutput("t4_exit_step", 32'(step_count), 32'd5);
    checkOutput("t4_exit_seg", 32'(seg), 32'(SEG_DASH));
    applyStimulus(1'b0, 3'b010, 1'b1);
    tick(3);
    checkOutput("t4_rerun", 32'(running), 32'd1);
    waitTempo("t4_p1", 8, 4'd6);

    // 5: mode 0 for 17 periods, step counter wraps 15 -> 0
    applyStimulus(1'b0, 3'b001, 1'b1);
    tick(3);
    checkOutput("t5_mode", 32'(mode_idx), 32'd0);
    checkOutput("t5_seg", 32'(seg), 32'(SEG_1));
    for (int i = 1; i <= 17; i++) begin
      waitTempo($sformatf("t5_p%0d", i), 4, 4'((6 + i) % 16));
    end

    // 6: reset mid-period
    tick(2);
    applyStimulus(1'b1, 3'b001, 1'b1);
    tick(1);
    checkResetState("t6_rst");
    applyStimulus(1'b0, 3'b001, 1'b1);
    tick(2);
    checkOutput("t6_not_yet_running", 32'(running), 32'd0);
    tick(1);
    checkOutput("t6_running", 32'(running), 32'd1);
    waitTempo("t6_p1", 4, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
